alu_cmd_issue: RTL
==================

Name: alu_cmd_issue

Overview:
- Command-issue stage directly upstream of the registered N-bit ALU top.
- Buffers operand/operation commands in a small FIFO and drives the ALU's operand1/operand2/operation inputs.
- Captures the ALU's registered result exactly one cycle after issue and presents it on a valid/ready response port.
- Adds flow control around an ALU that has none of its own: no enable, no valid, 1-cycle registered latency.

Parameters:
- N, 1, operand/result width; must match the ALU instance.
- DEPTH, 4, command FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_opnd1  in  N  command operand 1.
- cmd_opnd2  in  N  command operand 2.
- cmd_op  in  2  command operation code, passed through opaque.
- alu_operand1  out  N  to ALU operand1.
- alu_operand2  out  N  to ALU operand2.
- alu_operation  out  2  to ALU operation.
- alu_result  in  N  from ALU result; registered, 1-cycle latency.
- rsp_valid  out  1  response holds a result.
- rsp_ready  in  1  downstream accepts the response.
- rsp_data  out  N  captured ALU result.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. While reset is sampled high: FIFO emptied (count=0, pointers=0), busy=0, rsp_valid=0, rsp_data=0.
- Reset mid-operation: any in-flight result is discarded, not captured. cmd_ready is high in the first cycle after reset deasserts.
- Push: cmd_ready = (count != DEPTH), no pass-through when full. push = cmd_valid && cmd_ready. The entry {opnd1, opnd2, op} is written at the wr pointer; the pointer wraps modulo DEPTH.
- Head drive: alu_operand1/2 and alu_operation are driven combinationally from the FIFO head entry. When the FIFO is empty they hold the last-read entry (stale). The ALU computes every cycle; results of non-issue cycles are ignored.
- Issue: issue = (count != 0) && !busy && (!rsp_valid || rsp_ready).
- On issue in cycle t: the head is popped at the end of t and busy is set.
- Capture: in cycle t+1 (busy=1), alu_result holds the ALU's registered output of the operands presented in t.
  - At the end of t+1: rsp_data <= alu_result, rsp_valid <= 1, busy <= 0.
  - rsp_valid is first high in cycle t+2.
- Latency: command accepted in cycle c with an empty, idle block -> issue at c+1 -> rsp_valid at c+3.
- Throughput: at most one issue per 2 cycles, since no issue occurs while busy. The response slot is guaranteed free at capture because the issue condition requires the slot free or draining in cycle t.
- Response handshake:
  - Clear: rsp_valid falls at the end of a cycle with rsp_valid && rsp_ready, unless a capture sets it in the same edge. Capture has priority, so rsp_valid stays 1 with new data.
  - Hold: rsp_data and rsp_valid remain stable while rsp_valid && !rsp_ready.
- Occupancy: count increments on push only, decrements on issue only, and is unchanged on simultaneous push and issue.
  - Full with issue in the same cycle: cmd_ready is low that cycle (registered count); no push.
  - Empty: no issue; a push in the same cycle is not issuable until the next cycle.
- Ordering: responses are strictly FIFO order of accepted commands; none dropped, none duplicated.
- cmd_op is never interpreted; its encoding belongs to the ALU.

Test Plan:
Bench drives alu_result from an ALU model: registered opnd1+opnd2 mod 16, ignoring op. N=4, DEPTH=4.
- Single command: after reset, push {3,5,op=0} at cycle 2 -> alu_operand1=3, alu_operand2=5 at cycle 3; rsp_valid=1, rsp_data=8 at cycle 5; rsp_ready=1 clears it at cycle 6.
- Full: hold rsp_ready=0, push 6 commands {i,1} for i=0..5 back to back.
  - One command issues, then issue stalls.
  - cmd_ready drops when count=4; it reaches 4 only after the first issue.
  - The 6th command waits until space frees.
- Drain order: with the FIFO full, set rsp_ready=1 -> rsp_data sequence 1,2,3,4,5,6; new rsp_valid every 2 cycles; count reaches 0.
- Backpressure hold: rsp_valid=1, rsp_data=9, rsp_ready=0 for 5 cycles -> rsp_data stays 9; alu_operand* unchanged; no pop.
- Reset mid-flight: assert reset in the capture cycle (busy=1) -> next cycle rsp_valid=0, rsp_data=0, count=0, cmd_ready=1; no spurious response afterward.
- Wrap-around: push/pop 10 commands {15,i} with rsp_ready=1 -> pointers wrap twice; rsp_data = (15+i) mod 16 in order, e.g. i=3 -> 2.

Source files
------------

// File: rtl/alu_cmd_issue.sv
// ---------------------------------------------------------------------------
// alu_cmd_issue : command FIFO + issue/capture flow control for a 1-cycle ALU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_cmd_issue #(
   parameter int N     = 1,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [N-1:0]           cmd_opnd1,
   input  logic [N-1:0]           cmd_opnd2,
   input  logic [1:0]             cmd_op,
   output logic [N-1:0]           alu_operand1,
   output logic [N-1:0]           alu_operand2,
   output logic [1:0]             alu_operation,
   input  logic [N-1:0]           alu_result,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [N-1:0]           rsp_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 * N + 2;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [EW-1:0] last_entry;
   logic [EW-1:0] head;
   logic          busy;
   logic          push;
   logic          issue;
   logic          empty;

   assign empty     = (count == '0);
   assign cmd_ready = (count != FULL_COUNT);
   assign push      = cmd_valid && cmd_ready;
   assign issue     = !empty && !busy && (!rsp_valid || rsp_ready);

   // An empty FIFO keeps presenting the entry most recently issued.
   assign head = empty ? last_entry : mem[rd_ptr];
   assign {alu_operand1, alu_operand2, alu_operation} = head;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_opnd1, cmd_opnd2, cmd_op};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         last_entry <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (issue) begin
            rd_ptr     <= rd_ptr + AW'(1);
            last_entry <= head;
         end
         case ({push, issue})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // The ALU result is valid exactly one cycle after issue; capture wins over
   // a same-cycle response drain, so the slot refills without a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         if (busy) begin
            rsp_data  <= alu_result;
            rsp_valid <= 1'b1;
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         busy <= issue;
      end
   end

endmodule

`default_nettype wire
